// File: rtl/iobus_responder.sv
// Memory-mapped IO responder for the Starfish IOBUS: LED register, cycle counter,
// countdown timer with sticky interrupt, and a FIFO-fed 8N1 UART transmitter.
module iobus_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_0000,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic [15:0] leds,
    output logic        tmr_irq,
    output logic        uart_tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

    // state | meaning: IDLE line high, waiting | START start bit | DATA 8 bits LSB first | STOP stop bit
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    uart_state_t state, state_nxt;

    logic        hit;
    logic [3:0]  off;
    logic        wr_leds, wr_load, wr_ctrl, wr_data, wr_stat;
    logic        unused_addr_bits;

    logic [31:0] cycle;
    logic [31:0] tmr_load, tmr_count;
    logic        tmr_en, tmr_auto;
    logic        tmr_step, tmr_expire;

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr, fifo_cnt;
    logic        fifo_empty, fifo_full;
    logic        push, pop, ovf, ovf_set;

    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          baud_done;
    logic          busy;

    assign hit              = (IOBUS_ADDR[31:6] == BASE_ADDR[31:6]);
    assign off              = IOBUS_ADDR[5:2];
    assign unused_addr_bits = ^IOBUS_ADDR[1:0];

    assign wr_leds = IOBUS_WR && hit && (off == 4'h0);
    assign wr_load = IOBUS_WR && hit && (off == 4'h2);
    assign wr_ctrl = IOBUS_WR && hit && (off == 4'h3);
    assign wr_data = IOBUS_WR && hit && (off == 4'h5);
    assign wr_stat = IOBUS_WR && hit && (off == 4'h6);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leds  <= '0;
            cycle <= '0;
        end else begin
            cycle <= cycle + 32'd1;
            if (wr_leds) leds <= IOBUS_OUT[15:0];
        end
    end

    // A load write pre-empts the decrement, so it also suppresses that cycle's expiry.
    assign tmr_step   = tmr_en && (tmr_count != 32'd0) && !wr_load;
    assign tmr_expire = tmr_step && (tmr_count == 32'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_load  <= '0;
            tmr_count <= '0;
            tmr_en    <= 1'b0;
            tmr_auto  <= 1'b0;
            tmr_irq   <= 1'b0;
        end else begin
            if (wr_load) begin
                tmr_load  <= IOBUS_OUT;
                tmr_count <= IOBUS_OUT;
            end else if (tmr_expire) begin
                tmr_count <= tmr_auto ? tmr_load : 32'd0;
            end else if (tmr_step) begin
                tmr_count <= tmr_count - 32'd1;
            end
            if (wr_ctrl) begin
                tmr_en   <= IOBUS_OUT[0];
                tmr_auto <= IOBUS_OUT[1];
            end
            if (tmr_expire)
                tmr_irq <= 1'b1;
            else if (wr_ctrl && IOBUS_OUT[2])
                tmr_irq <= 1'b0;
        end
    end

    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_C);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push       = wr_data && (!fifo_full || pop);
    assign ovf_set    = wr_data && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= IOBUS_OUT[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW + 1)'(1);
            if (ovf_set)
                ovf <= 1'b1;
            else if (wr_stat && IOBUS_OUT[3])
                ovf <= 1'b0;
        end
    end

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        uart_tx   = 1'b1;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                uart_tx = 1'b0;
                if (baud_done) state_nxt = S_DATA;
            end
            S_DATA: begin
                uart_tx = shreg[bit_idx];
                if (baud_done && (bit_idx == 3'd7)) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (baud_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) || baud_done)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + BW'(1);
            if (state != S_DATA)
                bit_idx <= '0;
            else if (baud_done)
                bit_idx <= bit_idx + 3'd1;
            if (pop) shreg <= fifo_mem[rd_ptr[PW-1:0]];
        end
    end

    always_comb begin
        IOBUS_IN = '0;
        if (hit) begin
            case (off)
                4'h0:    IOBUS_IN = {16'd0, leds};
                4'h1:    IOBUS_IN = cycle;
                4'h2:    IOBUS_IN = tmr_load;
                4'h3:    IOBUS_IN = {29'd0, tmr_irq, tmr_auto, tmr_en};
                4'h4:    IOBUS_IN = tmr_count;
                4'h6:    IOBUS_IN = {28'd0, ovf, busy, fifo_full, fifo_empty};
                default: IOBUS_IN = '0;
            endcase
        end
    end

endmodule
